// File: rtl/smplfifo_pkg.sv
// smplfifo_pkg: shared definitions for the smplfifo_mc sample FIFO.
//   cw_of()          channel-tag width for a given channel count (min 1 bit)
//   OVW_DROP/OVERWRITE  overflow policy selectors for the OVW parameter
//   ST_*             bit offsets of the fields packed into o_status
package smplfifo_pkg;

  localparam int unsigned OVW_DROP      = 0;
  localparam int unsigned OVW_OVERWRITE = 1;

  localparam int unsigned ST_EMPTYN = 0;
  localparam int unsigned ST_ERR    = 1;
  localparam int unsigned ST_THRESH = 2;
  localparam int unsigned ST_HALF   = 3;
  localparam int unsigned ST_FILL   = 4;

  function automatic int unsigned cw_of(input int unsigned nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/smplfifo_ram.sv
// smplfifo_ram: simple dual-port synchronous RAM, one write port and one
// registered read port. Read-during-write to the same address returns the
// old contents; the FIFO top bypasses that case itself.
//   i_clk            clock
//   i_we/i_waddr/i_wdata  write port
//   i_raddr          read address, sampled on the clock edge
//   o_rdata          registered read data
module smplfifo_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 13
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/smplfifo_mc.sv
// smplfifo_mc: tagged sample FIFO between the PMod MIC sample front-end and
// the wishbone register slave. First-word-fall-through, exact fill count,
// programmable threshold flag, synchronous flush, selectable overflow policy.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_flush          synchronous empty, beats i_wr/i_rd
//   i_clr_err        clear sticky error bits (a same-cycle error event wins)
//   i_wr/i_chan/i_data  write strobe, channel tag, sample
//   i_rd             pop strobe, ignored while empty
//   i_thresh         fill threshold for o_thresh
//   o_empty_n        FIFO not empty
//   o_chan/o_data    oldest entry; held at last value while empty
//   o_fill           occupancy 0..FLEN
//   o_thresh         o_fill >= i_thresh (registered with o_fill)
//   o_status         {fill[11:0], half, thresh, err, empty_n}
//   o_err            sticky overflow (| underflow when enabled)
// Build option: define SMPLFIFO_UNDERFLOW_EN to make a pop on an empty FIFO
// set a sticky underflow bit reported through o_err.
module smplfifo_mc
  import smplfifo_pkg::*;
#(
  parameter int unsigned BW     = 12,
  parameter int unsigned LGFLEN = 9,
  parameter int unsigned NCH    = 2,
  parameter int unsigned OVW    = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_clr_err,
  input  logic                   i_wr,
  input  logic [cw_of(NCH)-1:0]  i_chan,
  input  logic [BW-1:0]          i_data,
  input  logic                   i_rd,
  input  logic [LGFLEN:0]        i_thresh,
  output logic                   o_empty_n,
  output logic [cw_of(NCH)-1:0]  o_chan,
  output logic [BW-1:0]          o_data,
  output logic [LGFLEN:0]        o_fill,
  output logic                   o_thresh,
  output logic [15:0]            o_status,
  output logic                   o_err
);

  localparam int unsigned CW = cw_of(NCH);
  localparam int unsigned DW = CW + BW;
  localparam logic [LGFLEN:0] FULL_LVL = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0] HALF_LVL = {2'b01, {(LGFLEN-1){1'b0}}};

  logic [LGFLEN-1:0] wptr_q, rptr_q, rptr_nxt;
  logic [LGFLEN:0]   fill_q, fill_nxt;
  logic              full, pop, wr_ok, ovf_evt, ovw_evt, inc;
  logic [DW-1:0]     wdata, ram_rdata, byp_data_q, head, hold_q;
  logic              byp_q, ovf_q, thresh_q, half_q, err;

  always_comb begin
    full    = (fill_q == FULL_LVL);
    pop     = i_rd && !i_flush && (fill_q != '0);
    wr_ok   = i_wr && !i_flush && (!full || pop || (OVW == OVW_OVERWRITE));
    ovf_evt = i_wr && !i_flush && full && !pop;
    // Overwrite-oldest: write lands on the slot under rptr, rptr steps past it.
    ovw_evt = wr_ok && full && !pop;
    inc     = wr_ok && !ovw_evt;

    rptr_nxt = rptr_q;
    fill_nxt = fill_q;
    if (i_flush) begin
      rptr_nxt = '0;
      fill_nxt = '0;
    end else begin
      if (pop || ovw_evt) rptr_nxt = rptr_q + 1'b1;
      fill_nxt = fill_q + (LGFLEN+1)'(inc) - (LGFLEN+1)'(pop);
    end
  end

  assign wdata = {i_chan, i_data};

  // The RAM is read at the post-update read pointer every cycle, so its
  // registered output is the head entry one cycle later. The only stale case
  // is a write to that same slot in the same cycle, covered by the bypass.
  smplfifo_ram #(
    .AW(LGFLEN),
    .DW(DW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_ok),
    .i_waddr (wptr_q),
    .i_wdata (wdata),
    .i_raddr (rptr_nxt),
    .o_rdata (ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      hold_q     <= '0;
      thresh_q   <= 1'b0;
      half_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (i_flush)    wptr_q <= '0;
      else if (wr_ok) wptr_q <= wptr_q + 1'b1;
      rptr_q     <= rptr_nxt;
      fill_q     <= fill_nxt;
      byp_q      <= wr_ok && (wptr_q == rptr_nxt);
      byp_data_q <= wdata;
      if (fill_q != '0) hold_q <= head;
      thresh_q   <= (fill_nxt >= i_thresh);
      half_q     <= (fill_nxt >= HALF_LVL);
      if (ovf_evt)        ovf_q <= 1'b1;
      else if (i_clr_err) ovf_q <= 1'b0;
    end
  end

`ifdef SMPLFIFO_UNDERFLOW_EN
  logic udf_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  udf_q <= 1'b0;
    else if (i_rd && !i_flush && (fill_q == '0))   udf_q <= 1'b1;
    else if (i_clr_err)                            udf_q <= 1'b0;
  end
  assign err = ovf_q | udf_q;
`else
  assign err = ovf_q;
`endif

  always_comb begin
    head      = byp_q ? byp_data_q : ram_rdata;
    o_empty_n = (fill_q != '0);
    o_data    = o_empty_n ? head[BW-1:0]  : hold_q[BW-1:0];
    o_chan    = o_empty_n ? head[DW-1:BW] : hold_q[DW-1:BW];
    o_fill    = fill_q;
    o_thresh  = thresh_q;
    o_err     = err;
    o_status  = '0;
    o_status[ST_FILL +: 12] = 12'(fill_q);
    o_status[ST_HALF]       = half_q;
    o_status[ST_THRESH]     = thresh_q;
    o_status[ST_ERR]        = err;
    o_status[ST_EMPTYN]     = o_empty_n;
  end

endmodule

// File: tb/tb_smplfifo_mc.sv
// tb_smplfifo_mc: directed-vector bench for smplfifo_mc. Two instances with
// LGFLEN=4 share one stimulus stream: u_drop (OVW=0) and u_ovw (OVW=1).
module tb_smplfifo_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0, clr_err = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [0:0]  chan = '0;
  logic [11:0] data = '0;
  logic [4:0]  thresh = 5'd8;

  logic        d_empty_n, d_thresh, d_err, v_empty_n, v_thresh, v_err;
  logic [0:0]  d_chan, v_chan;
  logic [11:0] d_data, v_data;
  logic [4:0]  d_fill, v_fill;
  logic [15:0] d_status, v_status;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  smplfifo_mc #(.BW(12), .LGFLEN(4), .NCH(2), .OVW(0)) u_drop (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
    .i_wr(wr), .i_chan(chan), .i_data(data), .i_rd(rd), .i_thresh(thresh),
    .o_empty_n(d_empty_n), .o_chan(d_chan), .o_data(d_data), .o_fill(d_fill),
    .o_thresh(d_thresh), .o_status(d_status), .o_err(d_err)
  );

  smplfifo_mc #(.BW(12), .LGFLEN(4), .NCH(2), .OVW(1)) u_ovw (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
    .i_wr(wr), .i_chan(chan), .i_data(data), .i_rd(rd), .i_thresh(thresh),
    .o_empty_n(v_empty_n), .o_chan(v_chan), .o_data(v_data), .o_fill(v_fill),
    .o_thresh(v_thresh), .o_status(v_status), .o_err(v_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] d);
    wr   = 1'b1;
    data = d;
    chan = d[0:0];
    tick();
    wr   = 1'b0;
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_empty_n", 32'(d_empty_n), 32'd0);
    check_val("rst_fill",    32'(d_fill),    32'd0);
    check_val("rst_data",    32'(d_data),    32'd0);
    check_val("rst_err",     32'(v_err),     32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single write into empty FIFO: visible next cycle
    wr = 1'b1; chan = 1'b1; data = 12'h0A5;
    tick();
    wr = 1'b0;
    check_val("w1_empty_n", 32'(d_empty_n), 32'd1);
    check_val("w1_data",    32'(d_data),    32'h0A5);
    check_val("w1_chan",    32'(d_chan),    32'd1);
    check_val("w1_fill",    32'(d_fill),    32'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check_val("p1_empty_n", 32'(d_empty_n), 32'd0);
    check_val("p1_hold",    32'(d_data),    32'h0A5);

    // 18 writes into depth-16: drop keeps 0..15, overwrite keeps 2..17.
    // Write 17 coincides with i_clr_err: the overflow event must win.
    for (int k = 0; k < 18; k++) begin
      if (k == 17) clr_err = 1'b1;
      push(12'(k));
      clr_err = 1'b0;
      if (k == 15) begin
        check_val("full_err_pre", 32'(d_err), 32'd0);
        check_val("full_fill16",  32'(d_fill), 32'd16);
      end
    end
    check_val("drop_fill",   32'(d_fill),   32'd16);
    check_val("drop_err",    32'(d_err),    32'd1);
    check_val("ovw_fill",    32'(v_fill),   32'd16);
    check_val("ovw_err",     32'(v_err),    32'd1);
    check_val("drop_status", 32'(d_status), 32'h010F);
    check_val("ovw_chan",    32'(v_chan),   32'd0);
    rd = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_val("drop_pop", 32'(d_data), 32'(k));
      check_val("ovw_pop",  32'(v_data), 32'(k + 2));
      tick();
    end
    rd = 1'b0;
    check_val("drain_fill",    32'(d_fill),    32'd0);
    check_val("drain_empty_n", 32'(v_empty_n), 32'd0);

    // Clear, refill, simultaneous write+pop on a full FIFO
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_val("clr_err", 32'(d_err), 32'd0);
    for (int k = 0; k < 16; k++) push(12'h100 + 12'(k));
    wr = 1'b1; data = 12'h3FF; chan = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0;
    check_val("wrpop_fill",    32'(d_fill), 32'd16);
    check_val("wrpop_err",     32'(d_err),  32'd0);
    check_val("wrpop_ovw_err", 32'(v_err),  32'd0);
    for (int k = 0; k < 16; k++) begin
      check_val("wrpop_seq", 32'(d_data), (k < 15) ? 32'h101 + 32'(k) : 32'h3FF);
      check_val("wrpop_ovw", 32'(v_data), (k < 15) ? 32'h101 + 32'(k) : 32'h3FF);
      tick();
    end
    rd = 1'b0;
    check_val("wrpop_empty", 32'(d_empty_n), 32'd0);

    // Threshold and half flags, then flush beating a write
    for (int k = 0; k < 7; k++) push(12'h020 + 12'(k));
    check_val("th7_fill",   32'(d_fill),   32'd7);
    check_val("th7_thresh", 32'(d_thresh), 32'd0);
    push(12'h027);
    check_val("th8_fill",   32'(d_fill),      32'd8);
    check_val("th8_thresh", 32'(d_thresh),    32'd1);
    check_val("th8_half",   32'(d_status[3]), 32'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check_val("thp_thresh", 32'(d_thresh),    32'd0);
    check_val("thp_half",   32'(d_status[3]), 32'd0);
    check_val("thp_data",   32'(d_data),      32'h021);
    flush = 1'b1; wr = 1'b1; data = 12'h555;
    tick();
    flush = 1'b0; wr = 1'b0;
    check_val("flush_fill",    32'(d_fill),    32'd0);
    check_val("flush_empty_n", 32'(d_empty_n), 32'd0);
    check_val("flush_ovw",     32'(v_fill),    32'd0);

    // Pop on empty
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check_val("udf_fill", 32'(d_fill), 32'd0);
`ifdef SMPLFIFO_UNDERFLOW_EN
    check_val("udf_err", 32'(d_err), 32'd1);
`else
    check_val("udf_err", 32'(d_err), 32'd0);
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_val("udf_clr", 32'(d_err), 32'd0);

    // Reset mid-burst takes effect immediately
    wr = 1'b1; data = 12'h0C3;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    wr = 1'b0;
    #1;
    check_val("mrst_fill",    32'(d_fill),    32'd0);
    check_val("mrst_empty_n", 32'(d_empty_n), 32'd0);
    check_val("mrst_data",    32'(v_data),    32'd0);
    @(negedge clk) rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
